// File: rtl/i2c_pkg.sv
// Shared types and constants for the emulated I2C temperature-sensor target.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_IGNORE
    } i2c_target_state_t;

    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;
    localparam int   BYTE_BITS = 8;

    function automatic int bytes_per_word(input int width);
        return width / BYTE_BITS;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// scl/sda synchronizer, optional 3-sample majority filter, and bus event detector.
// Optional filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_q, sda_q;
    logic scl_f, sda_f;
    logic scl_d, sda_d;

    // Reset to the idle bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

    assign scl_q = scl_sync[SYNC_STAGES-1];
    assign sda_q = sda_sync[SYNC_STAGES-1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_h, sda_h;

    // A one-clk spike only ever occupies one of the three taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_h <= '1;
            sda_h <= '1;
            scl_f <= 1'b1;
            sda_f <= 1'b1;
        end else begin
            scl_h <= {scl_h[0], scl_q};
            sda_h <= {sda_h[0], sda_q};
            scl_f <= (scl_q & scl_h[0]) | (scl_q & scl_h[1]) | (scl_h[0] & scl_h[1]);
            sda_f <= (sda_q & sda_h[0]) | (sda_q & sda_h[1]) | (sda_h[0] & sda_h[1]);
        end
    end
`else
    assign scl_f = scl_q;
    assign sda_f = sda_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_d;
    assign scl_fall  = ~scl_f & scl_d;
    assign start_det = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
    assign sda_s     = sda_f;

endmodule

// File: rtl/i2c_temp_sensor_target.sv
// I2C target emulating the temperature sensor: pointer write, MSB-first word read.
// Input glitch filter selected by I2C_TARGET_GLITCH_FILTER_EN (see i2c_bus_sync).
module i2c_temp_sensor_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] SENSOR_ADDRESS   = 7'b0000000,
    parameter int         CU_WIDTH         = 16,
    parameter logic [7:0] TARGET_READ_ADDR = 8'b00000000,
    parameter int         SYNC_STAGES      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                scl,
    inout  wire                 sda,
    input  logic [CU_WIDTH-1:0] temp_value,
    output logic [7:0]          reg_ptr,
    output logic                busy,
    output logic                read_done
);

    localparam int NB    = bytes_per_word(CU_WIDTH);
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    function automatic logic [7:0] word_byte(input logic [CU_WIDTH-1:0] w, input int idx);
        logic [CU_WIDTH-1:0] s;
        s = w >> ((NB - 1 - idx) * BYTE_BITS);
        return s[7:0];
    endfunction

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl       (scl),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_target_state_t state;
    logic [3:0]          bit_cnt;
    logic [7:0]          rx_sr, tx_sr;
    logic [CU_WIDTH-1:0] snap;
    logic [IDX_W-1:0]    byte_idx, next_idx;
    logic                ptr_seen;
    logic                sda_oe;
    logic [CU_WIDTH-1:0] word_src;
    logic [7:0]          first_byte, next_byte;

    // Open drain: only ever pull low; async reset clears sda_oe immediately.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    assign word_src   = (reg_ptr == TARGET_READ_ADDR) ? temp_value : '1;
    assign first_byte = word_byte(word_src, 0);
    assign next_idx   = (byte_idx == LAST_IDX) ? '0 : byte_idx + IDX_W'(1);
    assign next_byte  = word_byte(snap, int'(next_idx));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            snap      <= '0;
            byte_idx  <= '0;
            ptr_seen  <= 1'b0;
            sda_oe    <= 1'b0;
            reg_ptr   <= '0;
            busy      <= 1'b0;
            read_done <= 1'b0;
        end else begin
            read_done <= 1'b0;
            if (stop_det) begin
                state  <= ST_IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
            end else if (start_det) begin
                state    <= ST_ADDR;
                bit_cnt  <= '0;
                ptr_seen <= 1'b0;
                sda_oe   <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            rx_sr   <= {rx_sr[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (rx_sr[7:1] == SENSOR_ADDRESS) begin
                                sda_oe <= ~ACK;
                                busy   <= 1'b1;
                                state  <= ST_ADDR_ACK;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rx_sr[0]) begin
                                // Snapshot once per read so the word cannot tear.
                                snap     <= word_src;
                                byte_idx <= '0;
                                tx_sr    <= first_byte;
                                sda_oe   <= ~first_byte[7];
                                state    <= ST_TX_BYTE;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_PTR;
                            end
                        end
                    end
                    ST_PTR: begin
                        if (scl_rise) begin
                            rx_sr   <= {rx_sr[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (!ptr_seen) begin
                                reg_ptr  <= rx_sr;
                                ptr_seen <= 1'b1;
                                sda_oe   <= ~ACK;
                                state    <= ST_PTR_ACK;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_PTR_ACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            state  <= ST_PTR;
                        end
                    end
                    ST_TX_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= ST_TX_ACK;
                            end else begin
                                tx_sr  <= {tx_sr[6:0], 1'b0};
                                sda_oe <= ~tx_sr[6];
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise && sda_s == NACK) begin
                            read_done <= (byte_idx == LAST_IDX);
                            state     <= ST_IGNORE;
                        end else if (scl_fall) begin
                            byte_idx <= next_idx;
                            tx_sr    <= next_byte;
                            sda_oe   <= ~next_byte[7];
                            bit_cnt  <= '0;
                            state    <= ST_TX_BYTE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_temp_sensor_target.sv
// Self-checking bench: bit-banged I2C controller plus a byte-level model of the sensor target.
module tb_i2c_temp_sensor_target;

    localparam int SYNC_STAGES = 2;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int FILT_LAT = 2;
`else
    localparam int FILT_LAT = 0;
`endif
    localparam int Q = 80;   // quarter SCL period, 8 clk

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl;
    logic        ctl_low;
    logic [15:0] temp_value;
    wire         sda_bus;
    logic [7:0]  reg_ptr;
    logic        busy, read_done;

    always #5 clk = ~clk;

    pullup (sda_bus);
    assign sda_bus = ctl_low ? 1'b0 : 1'bz;

    i2c_temp_sensor_target dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl        (scl),
        .sda        (sda_bus),
        .temp_value (temp_value),
        .reg_ptr    (reg_ptr),
        .busy       (busy),
        .read_done  (read_done)
    );

    int         n_chk = 0, n_fail = 0;
    int         rd_pulses = 0, exp_pulses = 0;
    logic       chk_en = 1'b0, quiet_mon = 1'b0;
    logic [7:0] m_ptr = 8'h00;
    logic       m_busy = 1'b0;
    logic [7:0] rb [0:7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison of the DUT against the model state.
    always @(negedge clk) begin
        if (read_done === 1'b1) rd_pulses++;
        if (rst_n && chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            check("reg_ptr", {24'd0, reg_ptr}, {24'd0, m_ptr});
        end
        if (quiet_mon && !ctl_low) check("sda_quiet", {31'd0, sda_bus}, 32'd1);
    end

    task automatic bit_io(input logic b, output logic r);
        ctl_low = ~b;
        #(Q); scl = 1'b1;
        #(Q); r = sda_bus;
        #(Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic bus_start();
        chk_en  = 1'b0;
        ctl_low = 1'b0;
        #(Q); scl = 1'b1;
        #(Q); ctl_low = 1'b1;
        #(Q); scl = 1'b0;
        #(Q);
    endtask

    task automatic bus_stop();
        chk_en  = 1'b0;
        ctl_low = 1'b1;
        #(Q); scl = 1'b1;
        #(Q); ctl_low = 1'b0;
        #(Q);
        m_busy = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic wr_byte(input logic [7:0] v, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(v[i], r);
        bit_io(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] v);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, r);
            v[i] = r;
        end
        bit_io(nack, r);
    endtask

    // Addressed pointer write; leaves the bus held (no STOP).
    task automatic write_ptr(input logic [7:0] ptr);
        logic a;
        bus_start();
        wr_byte(8'h00, a);
        check("addr_ack_w", {31'd0, a}, 32'd0);
        m_busy = 1'b1;
        chk_en = 1'b1;
        #(Q);
        chk_en = 1'b0;
        wr_byte(ptr, a);
        check("ptr_ack", {31'd0, a}, 32'd0);
        m_ptr  = ptr;
        chk_en = 1'b1;
    endtask

    // Read n bytes, NACK the last, then STOP. Expected data from the model snapshot.
    task automatic read_txn(input int n, input logic chg, input logic [15:0] new_t);
        logic a;
        logic [15:0] snap, sh;
        logic [7:0] v;
        bus_start();
        wr_byte(8'h01, a);
        check("addr_ack_r", {31'd0, a}, 32'd0);
        m_busy = 1'b1;
        chk_en = 1'b1;
        snap = (m_ptr == 8'h00) ? temp_value : 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            rd_byte(k == n - 1, v);
            rb[k] = v;
            sh = snap >> (8 * (1 - (k % 2)));
            check("rd_byte", {24'd0, v}, {24'd0, sh[7:0]});
            if (chg && k == 0) temp_value = new_t;
        end
        if (((n - 1) % 2) == 1) exp_pulses++;
        bus_stop();
        check("read_done_cnt", rd_pulses, exp_pulses);
    endtask

    task automatic bad_addr(input logic [6:0] addr);
        logic a;
        quiet_mon = 1'b1;
        bus_start();
        wr_byte({addr, 1'b0}, a);
        check("addr_nack", {31'd0, a}, 32'd1);
        chk_en = 1'b1;
        wr_byte(8'h5A, a);
        check("data_nack", {31'd0, a}, 32'd1);
        bus_stop();
        quiet_mon = 1'b0;
    endtask

    initial begin
        logic       a, r;
        logic [3:0] nib;
        int         p0;
        logic [7:0] p;

        rst_n = 1'b0; scl = 1'b1; ctl_low = 1'b0; temp_value = 16'h1A2B;
        #50;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_reg_ptr", {24'd0, reg_ptr}, 32'd0);
        check("rst_read_done", {31'd0, read_done}, 32'd0);
        check("rst_sda", {31'd0, sda_bus}, 32'd1);
        rst_n = 1'b1;
        #(Q);
        chk_en = 1'b1;

        // Pointer 0, repeated START, two-byte read
        p0 = rd_pulses;
        write_ptr(8'h00);
        read_txn(2, 1'b0, 16'h0000);
        check("t1_b0", {24'd0, rb[0]}, 32'h1A);
        check("t1_b1", {24'd0, rb[1]}, 32'h2B);
        check("t1_done_once", rd_pulses - p0, 32'd1);

        // Wrong address: never driven, never busy
        bad_addr(7'h55);
        check("t2_busy", {31'd0, busy}, 32'd0);

        // Foreign pointer reads all-ones
        write_ptr(8'h07);
        bus_stop();
        read_txn(2, 1'b0, 16'h0000);
        check("t3_b0", {24'd0, rb[0]}, 32'hFF);
        check("t3_b1", {24'd0, rb[1]}, 32'hFF);
        check("t3_ptr", {24'd0, reg_ptr}, 32'h07);

        // No tearing when the live value changes mid-read
        write_ptr(8'h00);
        bus_stop();
        temp_value = 16'h1A2B;
        read_txn(2, 1'b1, 16'h3C4D);
        check("t4_b0", {24'd0, rb[0]}, 32'h1A);
        check("t4_b1", {24'd0, rb[1]}, 32'h2B);
        read_txn(2, 1'b0, 16'h0000);
        check("t4_n0", {24'd0, rb[0]}, 32'h3C);
        check("t4_n1", {24'd0, rb[1]}, 32'h4D);

        // Wrap after the last byte
        temp_value = 16'h1A2B;
        read_txn(4, 1'b0, 16'h0000);
        check("t6_b0", {24'd0, rb[0]}, 32'h1A);
        check("t6_b1", {24'd0, rb[1]}, 32'h2B);
        check("t6_b2", {24'd0, rb[2]}, 32'h1A);
        check("t6_b3", {24'd0, rb[3]}, 32'h2B);

        // STOP after four data bits (fifth bit of 0x1A is a released '1')
        bus_start();
        wr_byte(8'h01, a);
        check("t5_addr_ack", {31'd0, a}, 32'd0);
        m_busy = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            bit_io(1'b1, r);
            nib[i] = r;
        end
        check("t5_nibble", {28'd0, nib}, 32'h1);
        chk_en  = 1'b0;
        ctl_low = 1'b1;
        #(Q); scl = 1'b1;
        #(Q); ctl_low = 1'b0;
        repeat (SYNC_STAGES + 2 + FILT_LAT) @(posedge clk);
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_sda", {31'd0, sda_bus}, 32'd1);
        m_busy = 1'b0;
        #(Q);
        chk_en = 1'b1;
        read_txn(2, 1'b0, 16'h0000);
        check("t5_after_b0", {24'd0, rb[0]}, 32'h1A);

        // Reset while the target drives the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) bit_io((i == 0), r);
        ctl_low = 1'b0;
        #(Q);
        check("t7_ack_driven", {31'd0, sda_bus}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("t7_rst_sda", {31'd0, sda_bus}, 32'd1);
        check("t7_rst_busy", {31'd0, busy}, 32'd0);
        m_busy = 1'b0;
        m_ptr  = 8'h00;
        #(Q); scl = 1'b1;
        #(Q); rst_n = 1'b1;
        #(Q);
        chk_en = 1'b1;

        // Randomized traffic against the model
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    bad_addr(7'($urandom_range(1, 127)));
                end else begin
                    p = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(0, 255));
                    write_ptr(p);
                    bus_stop();
                end
            end else begin
                temp_value = 16'($urandom);
                read_txn(int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), 16'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
